jtag_host: RTL and testbench
============================

// Module: jtag_host
// PURPOSE
//   JTAG host (TAP driver). Drives tck/tms/tdi and samples tdo of a target TAP such as the LED blinky target.
//   Accepts one IR or DR scan command at a time over a valid/ready interface.
//   Walks the TAP from Run-Test/Idle through the scan and back to Run-Test/Idle.
//   Returns the bits captured on tdo. Sits between the test/firmware bus and the target's JTAG pins.
// PARAMETERS
//   MAX_BITS  32  longest scan length in bits; width of cmd_data/rsp_data
//   CLK_DIV   4   tck half-period in clk cycles (>=1)
// PORTS
//   clk        in   1                        system clock; only clock
//   rst        in   1                        synchronous, active-high reset
//   cmd_valid  in   1                        scan command present
//   cmd_ready  out  1                        host idle, command accepted when valid&ready
//   cmd_is_ir  in   1                        1 = IR scan, 0 = DR scan
//   cmd_len    in   $clog2(MAX_BITS+1)       number of bits to shift
//   cmd_data   in   MAX_BITS                 tdi bits, LSB shifted first
//   rsp_valid  out  1                        one-cycle pulse: scan complete
//   rsp_data   out  MAX_BITS                 captured tdo bits; held until next rsp_valid
//   busy       out  1                        scan or reset sequence in progress
//   tck        out  1                        JTAG clock
//   tms        out  1                        JTAG mode select
//   tdi        out  1                        JTAG data to target
//   tdo        in   1                        JTAG data from target
// BEHAVIOUR
//   - Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0.
//   - Reset applies mid-scan: the scan is abandoned with no rsp_valid. tck returns to 0 the cycle after rst.
//   - cmd_ready=1 in IDLE only; it rises the first cycle after rst deasserts (macro off).
//   - tck bit period = 2*CLK_DIV clk cycles: CLK_DIV cycles low, then CLK_DIV cycles high.
//   - tms/tdi are updated on the clk edge that drops tck (start of low phase).
//   - tdo is sampled on the clk edge that raises tck.
//   - First low phase begins the cycle after acceptance.
//   - FSM: IDLE -> HDR -> SHIFT -> TRL -> DONE -> IDLE (RST_SEQ added by macro).
//   - HDR tms sequence:
//       DR: 1,0,0 (Select-DR, Capture-DR, Shift-DR)
//       IR: 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR)
//   - SHIFT: L = cmd_len tck periods. tdi = cmd_data[i] for bit i; tms=0 except the last bit, tms=1 (Exit1).
//   - SHIFT capture: tdo sample of bit i -> rsp_data[i]. Bits >= L are 0.
//   - TRL tms sequence: 1 (Update), 0 (Run-Test/Idle).
//   - Total tck pulses: DR = L+5, IR = L+6.
//   - tdi=0 outside SHIFT.
//   - DONE: rsp_valid=1 for exactly one cycle, the cycle after the final high phase ends.
//     IDLE (cmd_ready=1) is the next cycle.
//   - cmd_len=0: accepted; no tck pulses; rsp_valid the cycle after acceptance; rsp_data=0.
//   - cmd_len>MAX_BITS: clamped to MAX_BITS.
//   - Inputs are registered at acceptance; later changes to cmd_* are ignored.
//   - busy = ~IDLE.
//   - Bit counter width $clog2(MAX_BITS+1); no wrap within a scan.
// CONFIGURATION
//   JTAG_HOST_TAP_RESET_EN
//     defined:
//       - After rst deasserts, FSM enters RST_SEQ.
//       - Drives 5 tck pulses with tms=1 (Test-Logic-Reset), then 1 pulse with tms=0 (Run-Test/Idle).
//       - busy=1 and cmd_ready=0 throughout; cmd_ready rises 6*2*CLK_DIV cycles after rst deasserts.
//       - No rsp_valid.
//     undefined:
//       - No RST_SEQ; target is assumed to already be in Run-Test/Idle.
// TESTING (CLK_DIV=2, MAX_BITS=32)
//   1. DR, len=8, data=0xA5, tdo looped to tdi
//      -> 13 tck pulses; tms per pulse 1,0,0,0x7,1,1,0; rsp_data=0x000000A5; rsp_valid 52 cycles after acceptance.
//   2. IR, len=4, data=0x2, tdo tied 1
//      -> 10 tck pulses; tms 1,1,0,0,0,0,0,1,1,0; tdi 0,1,0,0 during shift; rsp_data=0x0000000F.
//   3. len=0, cmd_valid
//      -> no tck edge; rsp_valid one cycle after acceptance; rsp_data=0; cmd_ready next cycle.
//   4. Two commands back-to-back with cmd_valid held
//      -> second accepted the cycle after rsp_valid; no extra tck pulse between scans.
//   5. rst asserted during SHIFT bit 3 of 16
//      -> next cycle tck=0, tms=1, busy=0, no rsp_valid; a new DR scan completes correctly.
//   6. Macro defined, release rst
//      -> 5 pulses tms=1, 1 pulse tms=0; cmd_ready=1 exactly 24 cycles later.

Source files
------------

// File: rtl/jtag_host.sv
// JTAG host: runs one IR/DR scan per command from Run-Test/Idle back to Run-Test/Idle.
// Optional macro JTAG_HOST_TAP_RESET_EN adds a Test-Logic-Reset walk after rst releases.
module jtag_host #(
  parameter int MAX_BITS = 32,
  parameter int CLK_DIV  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_is_ir,
  input  logic [$clog2(MAX_BITS+1)-1:0]   cmd_len,
  input  logic [MAX_BITS-1:0]             cmd_data,
  output logic                            rsp_valid,
  output logic [MAX_BITS-1:0]             rsp_data,
  output logic                            busy,
  output logic                            tck,
  output logic                            tms,
  output logic                            tdi,
  input  logic                            tdo
);
  localparam int LW = $clog2(MAX_BITS + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_BITS);

  typedef enum logic [2:0] {IDLE, HDR, SHIFT, TRL, DONE, RST_SEQ} state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       div_q, div_d;
  logic                ready_q, ready_d;
  logic                tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                ir_q, ir_d;
  logic [LW-1:0]       len_q, len_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic [MAX_BITS-1:0] cap_q, cap_d;
  logic [MAX_BITS-1:0] rsp_q, rsp_d;

  logic          accept, active, phase_end, rise, pulse_end, pulse_start, tdi_bit;
  logic [LW-1:0] len_eff;

  always_comb begin
    len_eff   = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    accept    = (state_q == IDLE) && ready_q && cmd_valid;
    active    = state_q inside {HDR, SHIFT, TRL, RST_SEQ};
    phase_end = active && (div_q == DIV_LAST);
    rise      = phase_end && !tck_q;
    pulse_end = phase_end && tck_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: every scan state advances only at the end of a tck high phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!ready_q) begin
`ifdef JTAG_HOST_TAP_RESET_EN
          state_d = RST_SEQ;
          cnt_d   = '0;
`endif
        end else if (cmd_valid) begin
          state_d = (len_eff == '0) ? DONE : HDR;
          cnt_d   = '0;
        end
      end
      HDR: if (pulse_end) begin
        if (cnt_q == (ir_q ? LW'(3) : LW'(2))) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      SHIFT: if (pulse_end) begin
        if (cnt_q == len_q - 1'b1) begin
          state_d = TRL;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      TRL: if (pulse_end) begin
        if (cnt_q == LW'(1)) state_d = DONE;
        else cnt_d = cnt_q + 1'b1;
      end
      RST_SEQ: if (pulse_end) begin
        if (cnt_q == LW'(5)) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin and datapath updates; tms/tdi for a pulse are set on the edge that opens its low phase
  always_comb begin
    ready_d = (state_d == IDLE);
    div_d   = div_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    ir_d    = ir_q;
    len_d   = len_q;
    data_d  = data_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;
    pulse_start = ((state_q == IDLE) || pulse_end) && (state_d inside {HDR, SHIFT, TRL, RST_SEQ});
    tdi_bit = |(data_q & (MAX_BITS'(1) << cnt_d));

    if (accept) begin
      ir_d   = cmd_is_ir;
      len_d  = len_eff;
      data_d = cmd_data;
      cap_d  = '0;
      if (len_eff == '0) rsp_d = '0;
    end
    if (active) begin
      if (phase_end) begin
        div_d = '0;
        tck_d = ~tck_q;
      end else div_d = div_q + 1'b1;
    end else begin
      div_d = '0;
      tck_d = 1'b0;
    end
    if (rise && state_q == SHIFT) cap_d = cap_q | (MAX_BITS'(tdo) << cnt_q);
    if (state_q == TRL && state_d == DONE) rsp_d = cap_q;
    if (pulse_start) begin
      tdi_d = 1'b0;
      unique case (state_d)
        HDR:     tms_d = (cnt_d == '0) || (ir_d && cnt_d == LW'(1));
        SHIFT: begin
          tms_d = (cnt_d == len_q - 1'b1);
          tdi_d = tdi_bit;
        end
        TRL:     tms_d = (cnt_d == '0);
        RST_SEQ: tms_d = (cnt_d != LW'(5));
        default: tms_d = tms_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      div_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      ir_q    <= 1'b0;
      len_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
    end else begin
      ready_q <= ready_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      ir_q    <= ir_d;
      len_q   <= len_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
    end
  end

  // Outputs
  always_comb begin
    cmd_ready = ready_q;
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == DONE);
    rsp_data  = rsp_q;
    tck       = tck_q;
    tms       = tms_q;
    tdi       = tdi_q;
  end
endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: directed and random scans against a pulse-level model of the TAP walk.
module tb_jtag_host;
  localparam int MAX_BITS = 32;
  localparam int CLK_DIV  = 2;
  localparam int LW       = $clog2(MAX_BITS + 1);
`ifdef JTAG_HOST_TAP_RESET_EN
  localparam int EXP_READY = 1 + 12 * CLK_DIV;
`else
  localparam int EXP_READY = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_is_ir = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic [MAX_BITS-1:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [MAX_BITS-1:0] rsp_data;

  int tdo_mode = 0;
  logic tdo_rand = 1'b0;
  assign tdo = (tdo_mode == 0) ? tdi : (tdo_mode == 1) ? 1'b1 : (tdo_mode == 2) ? 1'b0 : tdo_rand;

  jtag_host #(.MAX_BITS(MAX_BITS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rise_cnt = 0;
  int last_end = 0;
  logic [MAX_BITS-1:0] prev_rsp = '0;
  bit tms_log[$];
  bit tdi_log[$];
  bit tdo_log[$];
  logic prev_tck = 1'b0;
  bit nxt_ir;
  logic [LW-1:0] nxt_len;
  logic [MAX_BITS-1:0] nxt_data;

  // Pin monitor: logs tms/tdi/tdo at each tck rise; random tdo changes only after tck falls
  always @(negedge clk) begin
    if (tck === 1'b1 && prev_tck === 1'b0) begin
      tms_log.push_back(tms);
      tdi_log.push_back(tdi);
      tdo_log.push_back(tdo);
      rise_cnt++;
    end
    if (tck === 1'b0 && prev_tck === 1'b1) tdo_rand = 1'($urandom_range(0, 1));
    prev_tck = tck;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic after_reset(input string tag);
    int n = 0;
    int v = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
      if (rsp_valid) v++;
    end
    check({tag, ":ready_latency"}, 64'(n), 64'(EXP_READY));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) v++;
    end
    check({tag, ":no_rsp"}, 64'(v), 64'd0);
    last_end = rise_cnt;
    prev_rsp = '0;
  endtask

  task automatic run_scan(input bit ir, input int len, input logic [31:0] data,
                          input int mode, input bit hold, input string tag);
    int eff, hdr, np, start, n;
    logic [63:0] exp_tms, exp_tdi, obs_tms, obs_tdi;
    logic [MAX_BITS-1:0] exp_rsp;
    eff = (len > MAX_BITS) ? MAX_BITS : len;
    hdr = ir ? 4 : 3;
    np  = (eff == 0) ? 0 : hdr + eff + 2;
    tdo_mode = mode;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_is_ir = ir;
    cmd_len   = LW'(len);
    cmd_data  = data;
    @(posedge clk);
    start = rise_cnt;
    check({tag, ":gap_pulses"}, 64'(start - last_end), 64'd0);
    @(negedge clk);
    n = 1;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_is_ir = ~ir;
      cmd_len   = LW'($urandom_range(1, 40));
      cmd_data  = $urandom;
    end
    if (eff != 0) begin
      check({tag, ":busy"}, 64'(busy), 64'd1);
      check({tag, ":rsp_hold"}, 64'(rsp_data), 64'(prev_rsp));
    end
    while (!rsp_valid && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":latency"}, 64'(n), (eff == 0) ? 64'd1 : 64'(2 * CLK_DIV * np + 1));
    check({tag, ":pulses"}, 64'(rise_cnt - start), 64'(np));

    exp_tms = '0; exp_tdi = '0; obs_tms = '0; obs_tdi = '0; exp_rsp = '0;
    for (int k = 0; k < np; k++) begin
      if (k < hdr) exp_tms[k] = ir ? (k < 2) : (k == 0);
      else if (k < hdr + eff) begin
        exp_tms[k] = (k == hdr + eff - 1);
        exp_tdi[k] = data[k - hdr];
      end else exp_tms[k] = (k == hdr + eff);
      if (start + k < tms_log.size()) begin
        obs_tms[k] = tms_log[start + k];
        obs_tdi[k] = tdi_log[start + k];
      end
    end
    for (int k = 0; k < eff; k++) begin
      case (mode)
        0: exp_rsp[k] = data[k];
        1: exp_rsp[k] = 1'b1;
        2: exp_rsp[k] = 1'b0;
        default: exp_rsp[k] = (start + hdr + k < tdo_log.size()) ? tdo_log[start + hdr + k] : 1'b0;
      endcase
    end
    check({tag, ":tms_seq"}, obs_tms, exp_tms);
    check({tag, ":tdi_seq"}, obs_tdi, exp_tdi);
    check({tag, ":rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
    if (hold) begin
      cmd_is_ir = nxt_ir;
      cmd_len   = nxt_len;
      cmd_data  = nxt_data;
    end
    @(negedge clk);
    check({tag, ":rsp_pulse"}, 64'(rsp_valid), 64'd0);
    check({tag, ":ready_next"}, 64'(cmd_ready), 64'd1);
    last_end = rise_cnt;
    prev_rsp = exp_rsp;
  endtask

  initial begin
    int n;
    int start;
    repeat (3) @(negedge clk);
    check("reset:tck", 64'(tck), 64'd0);
    check("reset:tms", 64'(tms), 64'd1);
    check("reset:tdi", 64'(tdi), 64'd0);
    check("reset:cmd_ready", 64'(cmd_ready), 64'd0);
    check("reset:rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset:rsp_data", 64'(rsp_data), 64'd0);
    check("reset:busy", 64'(busy), 64'd0);
    rst = 1'b0;
    after_reset("release");

    run_scan(1'b0, 8, 32'h0000_00A5, 0, 1'b0, "dr8_loop");
    run_scan(1'b1, 4, 32'h0000_0002, 1, 1'b0, "ir4_ones");
    run_scan(1'b0, 0, 32'hFFFF_FFFF, 1, 1'b0, "len0");
    nxt_ir = 1'b1; nxt_len = LW'(5); nxt_data = 32'h0000_0013;
    run_scan(1'b0, 6, 32'h0000_002D, 0, 1'b1, "b2b_first");
    run_scan(nxt_ir, int'(nxt_len), nxt_data, 0, 1'b0, "b2b_second");
    run_scan(1'b0, 40, 32'hDEAD_BEEF, 3, 1'b0, "clamp40");
    run_scan(1'b1, 32, 32'h8000_0001, 0, 1'b0, "ir32_full");
    run_scan(1'b0, 1, 32'h0000_0001, 2, 1'b0, "dr1_zero");
    for (int i = 0; i < 12; i++)
      run_scan(1'($urandom_range(0, 1)), int'($urandom_range(0, 36)), $urandom,
               int'($urandom_range(0, 3)), 1'b0, $sformatf("rand%0d", i));

    // Abandon a 16-bit DR scan during shift bit 3
    tdo_mode = 0;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1; cmd_is_ir = 1'b0; cmd_len = LW'(16); cmd_data = $urandom;
    @(posedge clk);
    start = rise_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (rise_cnt - start < 7 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("midrst:reached_bit3", 64'(rise_cnt - start), 64'd7);
    rst = 1'b1;
    @(negedge clk);
    check("midrst:tck", 64'(tck), 64'd0);
    check("midrst:tms", 64'(tms), 64'd1);
    check("midrst:tdi", 64'(tdi), 64'd0);
    check("midrst:busy", 64'(busy), 64'd0);
    check("midrst:rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst:cmd_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    after_reset("midrst");
    run_scan(1'b0, 12, 32'h0000_0ACE, 0, 1'b0, "post_rst_dr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
